dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single DATA_MEMORY port between two requesters: port 0 (CPU load/store) and port 1 (debug/dump engine).
//  Round-robin arbitration, one transaction in flight, fixed-latency req/ack handshake on each side.
//  Drives the memory's MemRead/MemWrite/Address/Write_data; returns Read_Data to the granted requester.
//  Keeps saturating per-port grant counters for performance debug.
// PARAMETERS
//  ADDR_W  13  address width (8192 words)
//  DATA_W  32  data word width
//  CNT_W   16  width of each grant counter
// PORTS
//  clock        in   1       system clock, all logic on posedge
//  reset        in   1       synchronous, active-high
//  req0/req1    in   1       request; held with its fields until matching ack
//  we0/we1      in   1       1=write, 0=read; sampled with req
//  addr0/addr1  in   ADDR_W  word address
//  wdata0/1     in   DATA_W  write data
//  ack0/ack1    out  1       one-cycle completion pulse
//  rdata        out  DATA_W  read data; valid in the ack cycle of a read
//  mem_read     out  1       to DATA_MEMORY MemRead
//  mem_write    out  1       to DATA_MEMORY MemWrite
//  mem_addr     out  ADDR_W  to DATA_MEMORY Address
//  mem_wdata    out  DATA_W  to DATA_MEMORY Write_data
//  mem_rdata    in   DATA_W  from DATA_MEMORY Read_Data
//  busy         out  1       high whenever state != IDLE
//  gcnt0/gcnt1  out  CNT_W   grants issued to each port
// BEHAVIOUR
//  All outputs are registered. Reset values: ack*=0, rdata=0, mem_*=0, busy=0, gcnt*=0, state=IDLE, last=1 (port 0 wins first tie).
//  FSM states: IDLE, ISSUE, RDWAIT, DONE.
//  IDLE: if any req is high, pick the winner, latch we/addr/wdata/id, increment its gcnt, go to ISSUE.
//   - only one req high: that port wins.
//   - both high: the port != last wins; last <= winner.
//  ISSUE (1 cycle): mem_addr/mem_wdata = latched values; mem_write=we, mem_read=!we.
//   - write -> DONE; read -> RDWAIT.
//  RDWAIT (1 cycle): strobes low; rdata <= mem_rdata -> DONE.
//  DONE (1 cycle): ack[id]=1 -> IDLE. New request may not be granted before the next IDLE cycle.
//  Latency from first req-high cycle to ack cycle: write = 2 clocks, read = 3 clocks.
//  Back-to-back: min 3 cycles/write, 4 cycles/read per port.
//  mem_read/mem_write are never high together and are never high outside ISSUE.
//  mem_addr/mem_wdata hold their last values when idle. rdata holds until the next read completes.
//  Request fields are sampled only at grant. Changes while the request is in flight are ignored.
//  If req drops before ack, the transaction still completes and the ack is still issued.
//  A requester holding req through its ack cycle is treated as a new request in the next IDLE cycle.
//  gcnt saturates at all-ones and does not wrap.
//  reset mid-transaction: next cycle state=IDLE, strobes low, no ack, and last=1.
//   - An interrupted write may or may not have reached memory.
//  X on req is treated as 0.
// TESTING
//  T1 reset, req0 write addr=5 data=0xDEADBEEF
//   -> mem_write=1, mem_addr=5 in cycle 1; ack0 in cycle 2; gcnt0=1
//  T2 req0 read addr=5 (after T1), mem model returns stored word
//   -> mem_read in cycle 1; ack0 and rdata=0xDEADBEEF in cycle 3
//  T3 req0 and req1 both asserted from reset, both held continuously
//   -> grant order 0,1,0,1; ack0/ack1 alternate; gcnt0=gcnt1 after 4 grants
//  T4 req1 alone for 3 writes, then req0 and req1 together
//   -> port 0 wins the tie (last=1)
//  T5 reset asserted in RDWAIT of a port-1 read
//   -> no ack1; mem_read=0, busy=0, gcnt1 kept reset to 0 next cycle
//  T6 force gcnt0 to 0xFFFE, grant port 0 three times
//   -> gcnt0=0xFFFF, stays there; strobes never both high (assertion all tests)

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one DATA_MEMORY port between the CPU (port 0) and
// the debug/dump engine (port 1); one transaction in flight, all outputs registered.
module dmem_port_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  gcnt0,
    output logic [CNT_W-1:0]  gcnt1
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;

    state_t state, state_nxt;

    logic last;
    logic id_q;
    logic we_q;

    logic grant;
    logic win;
    logic we_sel;

    logic              ack0_d, ack1_d;
    logic [DATA_W-1:0] rdata_d;
    logic              mem_read_d, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              busy_d;
    logic [CNT_W-1:0]  gcnt0_d, gcnt1_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Winner selection; an unknown req falls through every branch and is treated as idle.
    always_comb begin
        grant = 1'b0;
        win   = 1'b0;
        if (state == IDLE) begin
            if (req0 && req1) begin
                grant = 1'b1;
                win   = ~last;
            end else if (req0) begin
                grant = 1'b1;
                win   = 1'b0;
            end else if (req1) begin
                grant = 1'b1;
                win   = 1'b1;
            end
        end
        we_sel = win ? we1 : we0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_q ? DONE : RDWAIT;
            RDWAIT:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs: strobes are loaded at grant so they are visible in ISSUE.
    always_comb begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rdata_d     = rdata;
        gcnt0_d     = gcnt0;
        gcnt1_d     = gcnt1;
        if (grant) begin
            mem_addr_d  = win ? addr1 : addr0;
            mem_wdata_d = win ? wdata1 : wdata0;
            mem_write_d = we_sel;
            mem_read_d  = ~we_sel;
            if (win) gcnt1_d = sat_inc(gcnt1);
            else     gcnt0_d = sat_inc(gcnt0);
        end
        if (state == RDWAIT) rdata_d = mem_rdata;
        ack0_d = (state_nxt == DONE) && !id_q;
        ack1_d = (state_nxt == DONE) &&  id_q;
        busy_d = (state_nxt != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last      <= 1'b1;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            gcnt0     <= '0;
            gcnt1     <= '0;
        end else begin
            if (grant) begin
                last <= win;
                id_q <= win;
                we_q <= we_sel;
            end
            ack0      <= ack0_d;
            ack1      <= ack1_d;
            rdata     <= rdata_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
            gcnt0     <= gcnt0_d;
            gcnt1     <= gcnt1_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: handshake latency, round-robin order,
// reset mid-read and grant-counter saturation against a small behavioural memory.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    // Narrow counters so saturation is reachable in a few dozen grants.
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic [CNT_W-1:0]  gcnt0, gcnt1;

    int n_vec      = 0;
    int n_miscmp   = 0;
    int strobe_bad = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .gcnt0(gcnt0), .gcnt1(gcnt1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    always @(negedge clock) begin
        if (mem_read && mem_write) strobe_bad++;
        if ((mem_read || mem_write) && !busy) strobe_bad++;
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] exp_g0;
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick();
        tick();
        check_vec("rst_ack0", ack0, 0);
        check_vec("rst_ack1", ack1, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_rdata", rdata, 0);
        check_vec("rst_mem_addr", mem_addr, 0);
        check_vec("rst_gcnt0", gcnt0, 0);
        reset = 1'b0;

        // T1: write 0xDEADBEEF to address 5 on port 0
        req0 = 1; we0 = 1; addr0 = 5; wdata0 = 32'hDEADBEEF;
        tick();
        check_vec("t1_mem_write", mem_write, 1);
        check_vec("t1_mem_read", mem_read, 0);
        check_vec("t1_mem_addr", mem_addr, 5);
        check_vec("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check_vec("t1_gcnt0", gcnt0, 1);
        check_vec("t1_busy", busy, 1);
        check_vec("t1_ack0_early", ack0, 0);
        tick();
        check_vec("t1_ack0", ack0, 1);
        check_vec("t1_strobe_off", mem_write, 0);
        req0 = 0;
        tick();
        check_vec("t1_ack0_pulse", ack0, 0);
        check_vec("t1_idle", busy, 0);
        check_vec("t1_addr_hold", mem_addr, 5);

        // T2: read back address 5; address change in flight must be ignored
        req0 = 1; we0 = 0; addr0 = 5;
        tick();
        check_vec("t2_mem_read", mem_read, 1);
        check_vec("t2_mem_write", mem_write, 0);
        check_vec("t2_gcnt0", gcnt0, 2);
        addr0 = 7;
        tick();
        check_vec("t2_rdwait_strobe", mem_read, 0);
        check_vec("t2_rdwait_ack", ack0, 0);
        check_vec("t2_addr_latched", mem_addr, 5);
        tick();
        check_vec("t2_ack0", ack0, 1);
        check_vec("t2_rdata", rdata, 32'hDEADBEEF);
        req0 = 0;
        tick();

        // T3: both ports from reset, held continuously -> grants 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0 = 1; we0 = 1; addr0 = 10; wdata0 = 32'hA0A0A0A0;
        req1 = 1; we1 = 1; addr1 = 20; wdata1 = 32'hB1B1B1B1;
        for (int g = 0; g < 4; g++) begin
            tick();
            check_vec($sformatf("t3_addr_g%0d", g), mem_addr, (g % 2 == 0) ? 10 : 20);
            tick();
            check_vec($sformatf("t3_ack0_g%0d", g), ack0, (g % 2 == 0) ? 1 : 0);
            check_vec($sformatf("t3_ack1_g%0d", g), ack1, (g % 2 == 1) ? 1 : 0);
            if (g == 3) begin
                req0 = 0;
                req1 = 0;
            end
            tick();
        end
        check_vec("t3_gcnt0", gcnt0, 2);
        check_vec("t3_gcnt1", gcnt1, 2);

        // T4: three solo port-1 writes, then a tie goes to port 0
        for (int k = 0; k < 3; k++) begin
            req1 = 1; we1 = 1; addr1 = 13'(30 + k); wdata1 = 32'(k);
            tick();
            check_vec($sformatf("t4_solo_addr%0d", k), mem_addr, 30 + k);
            tick();
            check_vec($sformatf("t4_solo_ack1_%0d", k), ack1, 1);
            req1 = 0;
            tick();
        end
        req0 = 1; we0 = 1; addr0 = 40; wdata0 = 32'h40;
        req1 = 1; we1 = 1; addr1 = 41; wdata1 = 32'h41;
        tick();
        check_vec("t4_tie_addr", mem_addr, 40);
        tick();
        check_vec("t4_tie_ack0", ack0, 1);
        check_vec("t4_tie_ack1", ack1, 0);
        req0 = 0;
        tick();
        tick();
        check_vec("t4_next_addr", mem_addr, 41);
        tick();
        check_vec("t4_next_ack1", ack1, 1);
        req1 = 0;
        tick();
        check_vec("t4_gcnt0", gcnt0, 3);
        check_vec("t4_gcnt1", gcnt1, 6);

        // T5: reset during RDWAIT of a port-1 read
        req1 = 1; we1 = 0; addr1 = 20;
        tick();
        check_vec("t5_mem_read", mem_read, 1);
        check_vec("t5_gcnt1", gcnt1, 7);
        tick();
        check_vec("t5_rdwait_busy", busy, 1);
        reset = 1'b1;
        req1 = 0;
        tick();
        check_vec("t5_no_ack1", ack1, 0);
        check_vec("t5_mem_read_off", mem_read, 0);
        check_vec("t5_busy", busy, 0);
        check_vec("t5_gcnt1_clr", gcnt1, 0);
        check_vec("t5_rdata_clr", rdata, 0);
        reset = 1'b0;
        req0 = 1; we0 = 1; addr0 = 50; wdata0 = 32'h50;
        req1 = 1; we1 = 1; addr1 = 51; wdata1 = 32'h51;
        tick();
        check_vec("t5_last_reset", mem_addr, 50);
        tick();
        check_vec("t5_ack0", ack0, 1);
        req0 = 0;
        req1 = 0;
        tick();
        tick();
        tick();
        req0 = 0;

        // T6: back-to-back port-0 writes drive gcnt0 into saturation
        exp_g0 = gcnt0 == 1 ? 1 : 0;
        check_vec("t6_gcnt0_start", gcnt0, 1);
        exp_g0 = 1;
        req0 = 1; we0 = 1; addr0 = 60; wdata0 = 32'h60;
        for (int i = 0; i < 16; i++) begin
            exp_g0 = (exp_g0 == CNT_MAX) ? CNT_MAX : exp_g0 + 1'b1;
            tick();
            check_vec($sformatf("t6_gcnt0_%0d", i), gcnt0, exp_g0);
            tick();
            check_vec($sformatf("t6_ack0_%0d", i), ack0, 1);
            if (i == 15) req0 = 0;
            tick();
        end
        check_vec("t6_gcnt0_sat", gcnt0, CNT_MAX);

        // T7: request withdrawn right after grant still completes with ack and data
        req0 = 1; we0 = 0; addr0 = 10;
        tick();
        req0 = 0;
        check_vec("t7_mem_read", mem_read, 1);
        tick();
        tick();
        check_vec("t7_ack0", ack0, 1);
        check_vec("t7_rdata", rdata, 32'hA0A0A0A0);
        tick();
        check_vec("t7_idle", busy, 0);
        check_vec("t7_gcnt0_sat", gcnt0, CNT_MAX);

        check_vec("strobe_excl", strobe_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
